// File: rtl/uart_recv.sv
// 8N1 serial receiver: synchronises rx, validates the start bit at mid-bit, samples each bit at its centre.
// Define UART_RECV_PARITY_EN to expect one even-parity bit after the data bits.
module uart_recv #(
  parameter int BAUD_RATE       = 9600,
  parameter int CLOCK_SPEED_MHZ = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  // Rounded to nearest so the bit period matches uart_send built with the same parameters.
  localparam int          CYCLES_WAIT = (CLOCK_SPEED_MHZ * 1000000 + BAUD_RATE / 2) / BAUD_RATE;
  localparam logic [15:0] CNT_FULL    = 16'(CYCLES_WAIT);
  localparam logic [15:0] CNT_HALF    = 16'(CYCLES_WAIT / 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RECV_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_err_q, frame_err_d;
`ifdef UART_RECV_PARITY_EN
  logic        par_err_q, par_err_d;
  logic        parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 16'd1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RECV_PARITY_EN
    par_err_d    = par_err_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) begin
          state_d = START;
`ifdef UART_RECV_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RECV_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RECV_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d     = '0;
          par_err_d = ^{shift_q, rx_sync_q};
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is not missed.
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_sync_q) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
`ifdef UART_RECV_PARITY_EN
            parity_err_d = par_err_q;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RECV_PARITY_EN
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RECV_PARITY_EN
      par_err_q    <= par_err_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);
`ifdef UART_RECV_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv at a short bit period (21 clk/bit); honours UART_RECV_PARITY_EN.
module tb_uart_recv;

  localparam int BIT = 21;  // CYCLES_WAIT = 20 at 20 MHz / 1 Mbaud

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_err, parity_err, busy;

  int checks = 0;
  int failures = 0;
  int dv_seen = 0, fe_seen = 0, pe_seen = 0, both_seen = 0;
  int exp_dv = 0, exp_fe = 0, exp_pe = 0;

  uart_recv #(.BAUD_RATE(1000000), .CLOCK_SPEED_MHZ(20)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(data_out),
    .data_valid(data_valid), .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) dv_seen++;
    if (frame_err) fe_seen++;
    if (parity_err) pe_seen++;
    if (data_valid && frame_err) both_seen++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
`ifdef UART_RECV_PARITY_EN
    hold_bit((^b) ^ par_flip);
`endif
    hold_bit(stop_b);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_dv"}, 16'(dv_seen), 16'(exp_dv));
    check({tag, "_fe"}, 16'(fe_seen), 16'(exp_fe));
    check({tag, "_pe"}, 16'(pe_seen), 16'(exp_pe));
  endtask

  initial begin
    // 1. reset with rx toggling
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx = ~rx;
    end
    check("rst_data", 16'(data_out), 16'h00);
    check("rst_pulses", {13'd0, data_valid, frame_err, parity_err}, 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (BIT) @(negedge clk);
    check("idle_busy", 16'(busy), 16'h0);

    // 2. good frame
    send_frame(8'hA5, 1'b1, 1'b0);
    exp_dv++;
    check("a5_data", 16'(data_out), 16'hA5);
    check("a5_busy", 16'(busy), 16'h0);
    check_counts("a5");

    // 3. glitch rejection
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_hi", 16'(busy), 16'h1);
    repeat (15) @(negedge clk);
    check("glitch_busy_lo", 16'(busy), 16'h0);
    repeat (BIT) @(negedge clk);
    check_counts("glitch");

    // 4. framing error, then recovery
    send_frame(8'h3C, 1'b0, 1'b0);
    exp_fe++;
    check("fe_data_kept", 16'(data_out), 16'hA5);
    check_counts("fe");
    hold_bit(1'b1);
    send_frame(8'h81, 1'b1, 1'b0);
    exp_dv++;
    check("81_data", 16'(data_out), 16'h81);
    check_counts("81");

    // 5. back-to-back frames
    send_frame(8'hFF, 1'b1, 1'b0);
    exp_dv++;
    check("ff_data", 16'(data_out), 16'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    exp_dv++;
    check("00_data", 16'(data_out), 16'h00);
    check_counts("b2b");

    // 6. reset during data bit 4 of 0x55
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(i[0] ? 1'b0 : 1'b1);
    rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    check("pre_rst_busy", 16'(busy), 16'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 16'(busy), 16'h0);
    check("midrst_data", 16'(data_out), 16'h00);
    repeat (3) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    hold_bit(1'b1);
    check_counts("midrst");
    send_frame(8'h12, 1'b1, 1'b0);
    exp_dv++;
    check("12_data", 16'(data_out), 16'h12);
    check_counts("12");

`ifdef UART_RECV_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    exp_dv++;
    exp_pe++;
    check("par_bad_data", 16'(data_out), 16'h07);
    check_counts("par_bad");
    send_frame(8'h07, 1'b1, 1'b0);
    exp_dv++;
    check_counts("par_good");
`endif

    check("dv_fe_overlap", 16'(both_seen), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
